// File: rtl/if_id_stage.sv
// Instruction-fetch stage: program counter plus IF/ID pipeline register.
// Optional performance counters are enabled by defining IF_STAGE_PERF_CNT_EN.
module if_id_stage #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]         NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pc_write_i,
    input  logic                if_id_hold_i,
    input  logic                branch_flush_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]         imem_data_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [31:0]         if_id_instr_o,
    output logic [PC_WIDTH-1:0] if_id_pc_plus4_o,
    output logic                if_id_valid_o
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         flush_cnt_o
`endif
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] target_aligned;

    // Wraps modulo 2^PC_WIDTH; no carry is reported.
    assign pc_plus4       = pc_o + PC_WIDTH'(4);
    assign target_aligned = branch_target_i & ~PC_WIDTH'(3);
    assign imem_addr_o    = pc_o;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_BOOT;
            pc_o             <= RESET_PC;
            if_id_instr_o    <= NOP_INSTR;
            if_id_pc_plus4_o <= '0;
            if_id_valid_o    <= 1'b0;
        end else begin
            case (state_q)
                // PC holds here so the word at RESET_PC is captured next edge.
                S_BOOT: begin
                    state_q          <= S_RUN;
                    if_id_instr_o    <= NOP_INSTR;
                    if_id_pc_plus4_o <= '0;
                    if_id_valid_o    <= 1'b0;
                end
                S_RUN: begin
                    if (branch_flush_i) begin
                        pc_o             <= target_aligned;
                        if_id_instr_o    <= NOP_INSTR;
                        if_id_pc_plus4_o <= '0;
                        if_id_valid_o    <= 1'b0;
                    end else begin
                        if (pc_write_i) begin
                            pc_o <= pc_plus4;
                        end
                        if (!if_id_hold_i) begin
                            if_id_instr_o    <= imem_data_i;
                            if_id_pc_plus4_o <= pc_plus4;
                            if_id_valid_o    <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (state_q == S_RUN) begin
            if (branch_flush_i) begin
                if (flush_cnt_o != '1) begin
                    flush_cnt_o <= flush_cnt_o + 32'd1;
                end
            end else if (!pc_write_i) begin
                if (stall_cnt_o != '1) begin
                    stall_cnt_o <= stall_cnt_o + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: vector table applied through a
// scoreboard queue, plus a second instance exercising PC wrap-around.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        if_id_hold;
    logic        branch_flush;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    logic        rst_w;
    logic [31:0] imem_addr_w;
    logic [31:0] pc_w;
    logic [31:0] if_id_instr_w;
    logic [31:0] if_id_pc_plus4_w;
    logic        if_id_valid_w;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] stall_cnt_w;
    logic [31:0] flush_cnt_w;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          rst;
        bit          pw;
        bit          hold;
        bit          flush;
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        bit          valid;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    // Instruction memory returns its address as data.
    if_id_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_write_i      (pc_write),
        .if_id_hold_i    (if_id_hold),
        .branch_flush_i  (branch_flush),
        .branch_target_i (branch_target),
        .imem_addr_o     (imem_addr),
        .imem_data_i     (imem_addr),
        .pc_o            (pc),
        .if_id_instr_o   (if_id_instr),
        .if_id_pc_plus4_o(if_id_pc_plus4),
        .if_id_valid_o   (if_id_valid)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    if_id_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i           (clk),
        .rst_i           (rst_w),
        .pc_write_i      (1'b1),
        .if_id_hold_i    (1'b0),
        .branch_flush_i  (1'b0),
        .branch_target_i (32'h0),
        .imem_addr_o     (imem_addr_w),
        .imem_data_i     (imem_addr_w),
        .pc_o            (pc_w),
        .if_id_instr_o   (if_id_instr_w),
        .if_id_pc_plus4_o(if_id_pc_plus4_w),
        .if_id_valid_o   (if_id_valid_w)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt_w),
        .flush_cnt_o     (flush_cnt_w)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add(input bit r, input bit pw, input bit hold, input bit fl, input logic [31:0] tgt,
                       input logic [31:0] epc, input logic [31:0] ein, input logic [31:0] ep4,
                       input bit ev, input logic [31:0] es, input logic [31:0] ef);
        vec_t v;
        v = '{r, pw, hold, fl, tgt, epc, ein, ep4, ev, es, ef};
        vecs.push_back(v);
    endtask

    // Drive one vector on the falling edge, score it just after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst           = v.rst;
        pc_write      = v.pw;
        if_id_hold    = v.hold;
        branch_flush  = v.flush;
        branch_target = v.target;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d pc", idx), pc, e.pc);
        check($sformatf("v%0d imem_addr", idx), imem_addr, e.pc);
        check($sformatf("v%0d instr", idx), if_id_instr, e.instr);
        check($sformatf("v%0d pc_plus4", idx), if_id_pc_plus4, e.pc4);
        check($sformatf("v%0d valid", idx), {31'b0, if_id_valid}, {31'b0, e.valid});
`ifdef IF_STAGE_PERF_CNT_EN
        check($sformatf("v%0d stall_cnt", idx), stall_cnt, e.scnt);
        check($sformatf("v%0d flush_cnt", idx), flush_cnt, e.fcnt);
`endif
    endtask

    initial begin
        rst           = 1'b1;
        rst_w         = 1'b1;
        pc_write      = 1'b1;
        if_id_hold    = 1'b0;
        branch_flush  = 1'b0;
        branch_target = '0;

        //   rst pw ho fl target          pc            instr         pc4           v  stall flush
        add(1, 1, 0, 0, 32'h0,          32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(1, 1, 0, 0, 32'h0,          32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(1, 1, 0, 0, 32'h0,          32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(0, 1, 0, 0, 32'h0,          32'h0,        32'h0,        32'h0,        0, 0, 0);  // boot edge
        add(0, 1, 0, 0, 32'h0,          32'h4,        32'h0,        32'h4,        1, 0, 0);
        add(0, 1, 0, 0, 32'h0,          32'h8,        32'h4,        32'h8,        1, 0, 0);
        add(0, 1, 0, 0, 32'h0,          32'hC,        32'h8,        32'hC,        1, 0, 0);
        add(0, 1, 0, 0, 32'h0,          32'h10,       32'hC,        32'h10,       1, 0, 0);
        add(0, 0, 1, 0, 32'h0,          32'h10,       32'hC,        32'h10,       1, 1, 0);  // load-use stall
        add(0, 1, 0, 0, 32'h0,          32'h14,       32'h10,       32'h14,       1, 1, 0);
        add(0, 1, 0, 0, 32'h0,          32'h18,       32'h14,       32'h18,       1, 1, 0);
        add(0, 1, 0, 0, 32'h0,          32'h1C,       32'h18,       32'h1C,       1, 1, 0);
        add(0, 1, 0, 0, 32'h0,          32'h20,       32'h1C,       32'h20,       1, 1, 0);
        add(0, 1, 0, 1, 32'h0000_0043,  32'h40,       32'h0,        32'h0,        0, 1, 1);  // branch
        add(0, 1, 0, 0, 32'h0,          32'h44,       32'h40,       32'h44,       1, 1, 1);
        add(0, 0, 1, 1, 32'h0000_0101,  32'h100,      32'h0,        32'h0,        0, 1, 2);  // flush beats stall
        add(0, 1, 0, 0, 32'h0,          32'h104,      32'h100,      32'h104,      1, 1, 2);
        add(0, 0, 0, 0, 32'h0,          32'h104,      32'h104,      32'h108,      1, 2, 2);  // PC frozen, IF/ID recaptures
        add(0, 1, 0, 0, 32'h0,          32'h108,      32'h104,      32'h108,      1, 2, 2);
        add(0, 1, 1, 0, 32'h0,          32'h10C,      32'h104,      32'h108,      1, 2, 2);  // only IF/ID frozen
        add(0, 1, 0, 1, 32'h30,         32'h30,       32'h0,        32'h0,        0, 2, 3);
        add(0, 0, 1, 0, 32'h0,          32'h30,       32'h0,        32'h0,        0, 3, 3);
        add(1, 0, 1, 0, 32'h0,          32'h0,        32'h0,        32'h0,        0, 0, 0);  // reset mid-stall
        add(0, 0, 1, 1, 32'h80,         32'h0,        32'h0,        32'h0,        0, 0, 0);  // boot ignores flush/stall
        add(0, 1, 0, 0, 32'h0,          32'h4,        32'h0,        32'h4,        1, 0, 0);
        add(1, 1, 0, 1, 32'h200,        32'h0,        32'h0,        32'h0,        0, 0, 0);  // reset beats flush
        add(0, 1, 0, 0, 32'h0,          32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(0, 1, 0, 0, 32'h0,          32'h4,        32'h0,        32'h4,        1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // PC wrap-around from RESET_PC = 0xFFFF_FFF8.
        @(negedge clk);
        rst_w = 1'b0;
        @(posedge clk);
        #1;
        check("wrap e1 pc", pc_w, 32'hFFFF_FFF8);
        check("wrap e1 valid", {31'b0, if_id_valid_w}, 32'h0);
        @(posedge clk);
        #1;
        check("wrap e2 pc", pc_w, 32'hFFFF_FFFC);
        check("wrap e2 instr", if_id_instr_w, 32'hFFFF_FFF8);
        check("wrap e2 pc_plus4", if_id_pc_plus4_w, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        check("wrap e3 pc", pc_w, 32'h0000_0000);
        check("wrap e3 instr", if_id_instr_w, 32'hFFFF_FFFC);
        check("wrap e3 pc_plus4", if_id_pc_plus4_w, 32'h0000_0000);
        check("wrap e3 valid", {31'b0, if_id_valid_w}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
